mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single memory port between two requesters: instruction fetch (F) and data load/store (D).
// - Sits between the controller (fetch path and load/store path) and the memory block.
// - Sequences each access, holds the memory bus stable for the read latency, and routes read data back.
// - Arbitrates between the two requesters round-robin. One access is outstanding at a time.
// PARAMETERS
// - ADDR_W        32  width of all addresses
// - DATA_W        32  width of read/write data
// - READ_LATENCY  1   cycles from address issue to valid mem_read_data (1..7)
// PORTS
// - clk              in   1       rising-edge clock
// - rst_n            in   1       asynchronous active-low reset
// - f_req            in   1       fetch request; held until f_gnt
// - f_addr           in   ADDR_W  fetch address
// - f_gnt            out  1       one-cycle pulse: fetch accepted
// - f_rvalid         out  1       one-cycle pulse: f_rdata valid
// - f_rdata          out  DATA_W  fetched instruction word
// - d_req            in   1       data request; held until d_gnt
// - d_we             in   1       1 = store, 0 = load
// - d_funct3         in   3       access size/sign code, passed to memory
// - d_addr           in   ADDR_W  load/store address
// - d_wdata          in   DATA_W  store data
// - d_gnt            out  1       one-cycle pulse: data access accepted
// - d_rvalid         out  1       one-cycle pulse: d_rdata valid (loads only)
// - d_rdata          out  DATA_W  load result
// - mem_read_address   out  ADDR_W  to memory read port
// - mem_write_mem      out  1       memory write enable
// - mem_write_address  out  ADDR_W  to memory write port
// - mem_write_data     out  DATA_W  to memory write port
// - mem_funct3         out  3       memory access size code
// - mem_read_data      in   DATA_W  from memory
// BEHAVIOUR
// - Reset: all outputs 0, except mem_funct3 = 3'b010. State = IDLE. last_gnt = D, so F wins the first tie.
// - All outputs are registered. Reset is asynchronous, and its release is synchronous to clk.
// - States:
//   - IDLE: arbitration runs every cycle in this state.
//   - RD_WAIT: latency counter runs.
//   - RESP: read data is returned.
// - IDLE, no req: hold. mem_write_mem = 0. mem_* address and data hold their last values.
// - IDLE, one req: grant it. Both req: grant the requester that is not last_gnt, then update last_gnt.
// - Grant edge (cycle N):
//   - The granted requester's gnt = 1 during cycle N+1 only.
//   - mem_* are driven from the granted request during cycle N+1.
// - F grant: mem_read_address = f_addr, mem_funct3 = 3'b010. Go to RD_WAIT. F never writes.
// - D load: mem_read_address = d_addr, mem_funct3 = d_funct3. Go to RD_WAIT.
// - D store:
//   - mem_write_address = d_addr, mem_write_data = d_wdata, mem_funct3 = d_funct3.
//   - mem_write_mem = 1 for exactly cycle N+1. Return to IDLE. No d_rvalid.
// - RD_WAIT:
//   - 3-bit counter loads READ_LATENCY-1 on entry and decrements each cycle.
//   - mem_read_address and mem_funct3 stay stable.
//   - Counter == 0: capture mem_read_data into the owner's rdata, go to RESP.
// - RESP: owner's rvalid = 1 for one cycle. Next state is IDLE.
// - Read data: rdata holds its value until the next read for the same requester. The other port is untouched.
// - Latency:
//   - Load/fetch: req seen at edge N -> gnt in N+1 -> rvalid in N+READ_LATENCY+2.
//   - Store: gnt and write_mem in N+1.
// - Throughput: an IDLE cycle always follows RESP. Back-to-back reads are READ_LATENCY+3 cycles apart; stores are 2 apart.
// - Requester contract:
//   - req and its fields stay stable until gnt. The block samples them only at the grant edge.
//   - req deasserted before gnt: the request is withdrawn and nothing is issued.
//   - req held high after gnt: treated as a new request at the next IDLE.
// - Starvation: with both req held continuously, grants alternate F, D, F, D.
// - A req arriving while busy waits for IDLE. gnt is never asserted outside the IDLE -> issue transition.
// - Reset mid-access: pending access dropped, no rvalid, write_mem forced 0 immediately (async).
// - Addresses and data pass through unmodified. No alignment checking: that belongs to the memory.
// TESTING
// - Reset, then f_req, f_addr=0x00, READ_LATENCY=1, mem returns 0x00100093:
//   - f_gnt 1 cycle after req; f_rvalid 3 cycles after req; f_rdata=0x00100093.
// - d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_funct3=3'b010:
//   - one-cycle mem_write_mem with addr 0x40, data 0xDEADBEEF; d_gnt same cycle; d_rvalid never asserted.
// - f_req and d_req asserted together out of reset, held 4 grants:
//   - grant order F, D, F, D. No gnt overlap. Each port's rdata is correct and untouched by the other port.
// - READ_LATENCY=3, d load of 0x80:
//   - mem_read_address = 0x80 stable for 3 cycles; d_rvalid at req+5; d_rdata equals mem word.
// - rst_n pulled low during RD_WAIT of a fetch:
//   - all outputs 0 asynchronously (mem_funct3 = 3'b010); no f_rvalid after release.
//   - next f_req is served normally.
// - d_req raised, then dropped while an F read is in RD_WAIT:
//   - no D access is issued; mem_write_mem stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (F) and load/store (D).
// Round-robin arbitration, one access outstanding at a time, every output registered.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_read_address,
    output logic              mem_write_mem,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;
    localparam logic [2:0] LAT_LOAD    = 3'(READ_LATENCY - 1);
    localparam logic       OWNER_F     = 1'b0;
    localparam logic       OWNER_D     = 1'b1;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                last_gnt_q, last_gnt_d;

    logic                f_gnt_q, f_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                f_rvalid_q, f_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0]   mem_read_address_q, mem_read_address_d;
    logic                mem_write_mem_q, mem_write_mem_d;
    logic [ADDR_W-1:0]   mem_write_address_q, mem_write_address_d;
    logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
    logic [2:0]          mem_funct3_q, mem_funct3_d;

    logic                issue_cycle;
    logic                can_arb;
    logic                grant_f;
    logic                grant_d;
    logic                read_done;

    // The cycle a gnt is visible is the issue cycle; no new arbitration may overlap it.
    assign issue_cycle = f_gnt_q | d_gnt_q;
    assign can_arb     = (state_q == IDLE) && !issue_cycle;
    assign grant_f     = can_arb && f_req && (!d_req || (last_gnt_q == OWNER_D));
    assign grant_d     = can_arb && d_req && (!f_req || (last_gnt_q == OWNER_F));
    assign read_done   = (state_q == RD_WAIT) && !issue_cycle && (cnt_q == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            cnt_q               <= 3'd0;
            owner_q             <= OWNER_F;
            last_gnt_q          <= OWNER_D;
            f_gnt_q             <= 1'b0;
            d_gnt_q             <= 1'b0;
            f_rvalid_q          <= 1'b0;
            d_rvalid_q          <= 1'b0;
            f_rdata_q           <= '0;
            d_rdata_q           <= '0;
            mem_read_address_q  <= '0;
            mem_write_mem_q     <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            mem_funct3_q        <= FUNCT3_WORD;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            owner_q             <= owner_d;
            last_gnt_q          <= last_gnt_d;
            f_gnt_q             <= f_gnt_d;
            d_gnt_q             <= d_gnt_d;
            f_rvalid_q          <= f_rvalid_d;
            d_rvalid_q          <= d_rvalid_d;
            f_rdata_q           <= f_rdata_d;
            d_rdata_q           <= d_rdata_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_mem_q     <= mem_write_mem_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            mem_funct3_q        <= mem_funct3_d;
        end
    end

    // The latency counter is loaded in the issue cycle, so the read data is sampled
    // exactly READ_LATENCY cycles after the address first appears on the bus.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (grant_f) begin
                    state_d    = RD_WAIT;
                    owner_d    = OWNER_F;
                    last_gnt_d = OWNER_F;
                end else if (grant_d) begin
                    owner_d    = OWNER_D;
                    last_gnt_d = OWNER_D;
                    if (!d_we) begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (issue_cycle) begin
                    cnt_d = LAT_LOAD;
                end else if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        f_gnt_d             = 1'b0;
        d_gnt_d             = 1'b0;
        f_rvalid_d          = 1'b0;
        d_rvalid_d          = 1'b0;
        f_rdata_d           = f_rdata_q;
        d_rdata_d           = d_rdata_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_mem_d     = 1'b0;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        mem_funct3_d        = mem_funct3_q;

        if (grant_f) begin
            f_gnt_d            = 1'b1;
            mem_read_address_d = f_addr;
            mem_funct3_d       = FUNCT3_WORD;
        end else if (grant_d) begin
            d_gnt_d      = 1'b1;
            mem_funct3_d = d_funct3;
            if (d_we) begin
                mem_write_mem_d     = 1'b1;
                mem_write_address_d = d_addr;
                mem_write_data_d    = d_wdata;
            end else begin
                mem_read_address_d = d_addr;
            end
        end

        // Only the owner's read data register is touched; the other port keeps its word.
        if (read_done) begin
            if (owner_q == OWNER_F) begin
                f_rvalid_d = 1'b1;
                f_rdata_d  = mem_read_data;
            end else begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = mem_read_data;
            end
        end
    end

    assign f_gnt             = f_gnt_q;
    assign d_gnt             = d_gnt_q;
    assign f_rvalid          = f_rvalid_q;
    assign d_rvalid          = d_rvalid_q;
    assign f_rdata           = f_rdata_q;
    assign d_rdata           = d_rdata_q;
    assign mem_read_address  = mem_read_address_q;
    assign mem_write_mem     = mem_write_mem_q;
    assign mem_write_address = mem_write_address_q;
    assign mem_write_data    = mem_write_data_q;
    assign mem_funct3        = mem_funct3_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at READ_LATENCY 1, one at READ_LATENCY 3,
// each backed by a small pipelined memory model that returns a fixed word per address.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    always #5 clk = ~clk;

    // READ_LATENCY = 1 instance
    logic        f_req    = 1'b0;
    logic [31:0] f_addr   = '0;
    logic        d_req    = 1'b0;
    logic        d_we     = 1'b0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_addr   = '0;
    logic [31:0] d_wdata  = '0;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid;
    logic [31:0] f_rdata, d_rdata;
    logic [31:0] mem_read_address, mem_write_address, mem_write_data;
    logic        mem_write_mem;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data = '0;

    // READ_LATENCY = 3 instance
    logic        f3_req    = 1'b0;
    logic [31:0] f3_addr   = '0;
    logic        d3_req    = 1'b0;
    logic        d3_we     = 1'b0;
    logic [2:0]  d3_funct3 = '0;
    logic [31:0] d3_addr   = '0;
    logic [31:0] d3_wdata  = '0;
    logic        f3_gnt, f3_rvalid, d3_gnt, d3_rvalid;
    logic [31:0] f3_rdata, d3_rdata;
    logic [31:0] mem3_read_address, mem3_write_address, mem3_write_data;
    logic        mem3_write_mem;
    logic [2:0]  mem3_funct3;
    logic [31:0] mem3_read_data = '0;
    logic [31:0] mem3_p1 = '0;
    logic [31:0] mem3_p2 = '0;

    int          vectors     = 0;
    int          miscompares = 0;
    int          gcount;
    int          rcount;
    logic [1:0]  exp_order [4];
    logic [31:0] exp_f, exp_d, held_f, held_d;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_read_address(mem_read_address), .mem_write_mem(mem_write_mem),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f3_req), .f_addr(f3_addr), .f_gnt(f3_gnt), .f_rvalid(f3_rvalid), .f_rdata(f3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_funct3(d3_funct3), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
        .mem_read_address(mem3_read_address), .mem_write_mem(mem3_write_mem),
        .mem_write_address(mem3_write_address), .mem_write_data(mem3_write_data),
        .mem_funct3(mem3_funct3), .mem_read_data(mem3_read_data)
    );

    // Memory contents: address 0 holds an addi instruction, everything else a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        mem_read_data <= mem_word(mem_read_address);
        mem3_p1        <= mem_word(mem3_read_address);
        mem3_p2        <= mem3_p1;
        mem3_read_data <= mem3_p2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                                 input logic [2:0] df, input logic [31:0] da, input logic [31:0] dd);
        f_req    = fr;
        f_addr   = fa;
        d_req    = dr;
        d_we     = dw;
        d_funct3 = df;
        d_addr   = da;
        d_wdata  = dd;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_f_gnt"}, f_gnt, 0);
        checkOutput({tag, "_d_gnt"}, d_gnt, 0);
        checkOutput({tag, "_f_rvalid"}, f_rvalid, 0);
        checkOutput({tag, "_d_rvalid"}, d_rvalid, 0);
        checkOutput({tag, "_f_rdata"}, f_rdata, 0);
        checkOutput({tag, "_d_rdata"}, d_rdata, 0);
        checkOutput({tag, "_rd_addr"}, mem_read_address, 0);
        checkOutput({tag, "_write_mem"}, mem_write_mem, 0);
        checkOutput({tag, "_wr_addr"}, mem_write_address, 0);
        checkOutput({tag, "_wr_data"}, mem_write_data, 0);
        checkOutput({tag, "_funct3"}, mem_funct3, 3'b010);
        checkOutput({tag, "_l3_gnt"}, {f3_gnt, d3_gnt, f3_rvalid, d3_rvalid, mem3_write_mem}, 0);
        checkOutput({tag, "_l3_rdata"}, f3_rdata | d3_rdata, 0);
        checkOutput({tag, "_l3_addr"}, mem3_read_address | mem3_write_address | mem3_write_data, 0);
        checkOutput({tag, "_l3_funct3"}, mem3_funct3, 3'b010);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        checkReset("reset");
        rst_n = 1'b1;
        tick();

        // Single fetch at latency 1
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        checkOutput("t1_f_gnt", f_gnt, 1);
        checkOutput("t1_d_gnt", d_gnt, 0);
        checkOutput("t1_rd_addr", mem_read_address, 32'h0);
        checkOutput("t1_funct3", mem_funct3, 3'b010);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        checkOutput("t1_gnt_pulse", f_gnt, 0);
        checkOutput("t1_early_rvalid", f_rvalid, 0);
        tick();
        checkOutput("t1_f_rvalid", f_rvalid, 1);
        checkOutput("t1_f_rdata", f_rdata, 32'h0010_0093);
        checkOutput("t1_d_rvalid", d_rvalid, 0);
        tick();
        checkOutput("t1_rvalid_pulse", f_rvalid, 0);

        // Store
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        tick();
        checkOutput("t2_d_gnt", d_gnt, 1);
        checkOutput("t2_write_mem", mem_write_mem, 1);
        checkOutput("t2_wr_addr", mem_write_address, 32'h40);
        checkOutput("t2_wr_data", mem_write_data, 32'hDEAD_BEEF);
        checkOutput("t2_funct3", mem_funct3, 3'b010);
        checkOutput("t2_f_gnt", f_gnt, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2_no_d_rvalid", d_rvalid, 0);
            checkOutput("t2_write_pulse", mem_write_mem, 0);
            checkOutput("t2_no_regrant", d_gnt, 0);
        end

        // Both requesters held from reset: F, D, F, D
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        f_addr   = 32'h200;
        d_addr   = 32'h100;
        d_we     = 1'b0;
        d_funct3 = 3'b000;
        f_req    = 1'b1;
        d_req    = 1'b1;
        exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
        gcount = 0;
        rcount = 0;
        exp_f  = '0;
        exp_d  = '0;
        held_f = '0;
        held_d = '0;
        for (int cyc = 0; cyc < 60 && rcount < 4; cyc++) begin
            tick();
            if (f_gnt || d_gnt) begin
                if (gcount < 4) begin
                    checkOutput("t3_gnt_order", {f_gnt, d_gnt}, exp_order[gcount]);
                end else begin
                    checkOutput("t3_extra_gnt", {f_gnt, d_gnt}, 0);
                end
                if (f_gnt) begin
                    exp_f  = mem_word(f_addr);
                    f_addr = f_addr + 32'h4;
                end
                if (d_gnt) begin
                    exp_d  = mem_word(d_addr);
                    d_addr = d_addr + 32'h4;
                end
                gcount++;
                if (gcount == 4) begin
                    f_req = 1'b0;
                    d_req = 1'b0;
                end
            end
            if (f_rvalid) begin
                checkOutput("t3_f_rdata", f_rdata, exp_f);
                checkOutput("t3_d_untouched", d_rdata, held_d);
                held_f = exp_f;
                rcount++;
            end
            if (d_rvalid) begin
                checkOutput("t3_d_rdata", d_rdata, exp_d);
                checkOutput("t3_f_untouched", f_rdata, held_f);
                held_d = exp_d;
                rcount++;
            end
        end
        checkOutput("t3_responses", rcount, 4);

        // Load at latency 3
        d3_req    = 1'b1;
        d3_we     = 1'b0;
        d3_addr   = 32'h80;
        d3_funct3 = 3'b100;
        tick();
        checkOutput("t4_d_gnt", d3_gnt, 1);
        checkOutput("t4_rd_addr", mem3_read_address, 32'h80);
        checkOutput("t4_funct3", mem3_funct3, 3'b100);
        d3_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4_addr_stable", mem3_read_address, 32'h80);
            checkOutput("t4_early_rvalid", d3_rvalid, 0);
        end
        tick();
        checkOutput("t4_d_rvalid", d3_rvalid, 1);
        checkOutput("t4_d_rdata", d3_rdata, 32'h5ADA_FF7F);

        // Asynchronous reset during the wait of a fetch
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        checkOutput("t5_f_gnt", f_gnt, 1);
        f_req = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("t5_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t5_no_rvalid", f_rvalid, 0);
            checkOutput("t5_no_gnt", f_gnt, 0);
        end
        applyStimulus(1'b1, 32'h304, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        checkOutput("t5_regrant", f_gnt, 1);
        f_req = 1'b0;
        tick();
        tick();
        checkOutput("t5_f_rvalid", f_rvalid, 1);
        checkOutput("t5_f_rdata", f_rdata, 32'h595E_FCFB);
        tick();

        // D request withdrawn while F is waiting
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        checkOutput("t6_f_gnt", f_gnt, 1);
        applyStimulus(1'b0, 32'h400, 1'b1, 1'b1, 3'b010, 32'h44, 32'h1234_5678);
        tick();
        d_req = 1'b0;
        tick();
        checkOutput("t6_f_rvalid", f_rvalid, 1);
        checkOutput("t6_f_rdata", f_rdata, 32'h5E5A_FBFF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t6_no_d_gnt", d_gnt, 0);
            checkOutput("t6_no_write", mem_write_mem, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
